// File: rtl/uart_tx.sv
// uart_tx: AXI-Stream byte in, asynchronous serial frame out.
// Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   s_axis_tdata   byte to send, latched on the handshake edge
//   s_axis_tvalid  upstream byte valid
//   s_axis_tready  registered; high only while idle and able to accept a byte
//   tx             registered serial line, idles high
//   busy           registered; high from the handshake until the frame ends
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             bit_done;

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; every bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        bit_done = (cnt_q == CNT_LAST);

        if (bit_done) begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                // Start bit goes out on the handshake edge itself.
                if (ready_q && s_axis_tvalid) begin
                    shift_d = s_axis_tdata;
                    par_d   = (^s_axis_tdata) ^ PAR_ODD;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign s_axis_tready = ready_q;
    assign tx            = tx_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: no parity/1 stop,
// even parity/2 stops and odd parity/2 stops instances share clk, rst and tdata.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tdata;
    logic       v0, ve, vo;
    logic       r0, re, ro;
    logic       t0, te, to;
    logic       b0, be, bo;

    logic [1:0] sel;
    logic       tx_sel, ready_sel, busy_sel, valid_sel;

    int  errors;
    int  checks;
    int  hs_cnt;
    logic busy_prev;
    time hs_time;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(v0),
        .s_axis_tready(r0), .tx(t0), .busy(b0));

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_dut_even (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(ve),
        .s_axis_tready(re), .tx(te), .busy(be));

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_dut_odd (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(vo),
        .s_axis_tready(ro), .tx(to), .busy(bo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd0:    begin tx_sel = t0; ready_sel = r0; busy_sel = b0; valid_sel = v0; end
            2'd1:    begin tx_sel = te; ready_sel = re; busy_sel = be; valid_sel = ve; end
            default: begin tx_sel = to; ready_sel = ro; busy_sel = bo; valid_sel = vo; end
        endcase
    end

    // A handshake is seen as a rising edge of busy on the selected instance.
    initial begin
        hs_cnt    = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_sel && !busy_prev) hs_cnt = hs_cnt + 1;
            busy_prev = busy_sel;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        case (sel)
            2'd0:    v0 = v;
            2'd1:    ve = v;
            default: vo = v;
        endcase
    endtask

    // Call at a negedge. Sends b, then presents after_data/after_valid for the
    // rest of the frame (optionally toggling valid), and checks every bit.
    task automatic run_frame(input string tag, input logic [7:0] b,
                             input logic [7:0] after_data, input logic after_valid,
                             input logic toggle, input int nbits,
                             input logic [11:0] bits_exp);
        int   budget;
        int   hs_before;
        logic [3:0] samp;
        tdata = b;
        set_valid(1'b1);
        budget = 0;
        while (!ready_sel && budget < 100) begin
            @(negedge clk);
            budget = budget + 1;
        end
        check({tag, "_ready_wait"}, 32'(ready_sel), 32'd1);
        hs_before = hs_cnt;
        @(posedge clk);
        hs_time = $time;
        #1;
        check({tag, "_tx_fall_on_hs"}, 32'(tx_sel), 32'd0);
        tdata = after_data;
        set_valid(after_valid);
        for (int k = 0; k < nbits; k++) begin
            samp = '0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                samp[c] = tx_sel;
                if (toggle) set_valid(~valid_sel);
                if (k == 0 && c == 0) check({tag, "_busy"}, 32'(busy_sel), 32'd1);
            end
            check($sformatf("%s_bit%0d", tag, k), 32'(samp), 32'({4{bits_exp[k]}}));
        end
        check({tag, "_ready_low_last"}, 32'(ready_sel), 32'd0);
        check({tag, "_one_hs"}, 32'(hs_cnt - hs_before), 32'd1);
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(ready_sel), 32'd1);
        check({tag, "_busy_clear"}, 32'(busy_sel), 32'd0);
        check({tag, "_tx_idle"}, 32'(tx_sel), 32'd1);
    endtask

    initial begin
        time t_first;
        int  budget;
        errors = 0;
        checks = 0;
        sel    = 2'd0;
        tdata  = 8'h00;
        v0 = 1'b0; ve = 1'b0; vo = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("rst_tx",    32'(t0), 32'd1);
        check("rst_busy",  32'(b0), 32'd0);
        check("rst_ready", 32'(r0), 32'd0);
        check("rst_ready_even", 32'(re), 32'd0);
        rst = 1'b1;
        #1 check("ready_before_edge", 32'(r0), 32'd0);
        @(negedge clk);
        check("ready_first_edge", 32'(r0), 32'd1);
        check("tx_idle", 32'(t0), 32'd1);

        // 0x55 -> 0,1,0,1,0,1,0,1,0,1 (first-sent bit is vector bit 0)
        run_frame("b55", 8'h55, 8'h00, 1'b0, 1'b0, 10, 12'h2AA);

        // Back-to-back 0xA3 then 0x0F with valid held
        run_frame("bA3", 8'hA3, 8'h0F, 1'b1, 1'b0, 10, 12'h346);
        t_first = hs_time;
        run_frame("b0F", 8'h0F, 8'h00, 1'b0, 1'b0, 10, 12'h21E);
        check("b2b_spacing", 32'((hs_time - t_first) / 10), 32'd41);

        // 0x3C latched, then 0xFF presented with valid toggling
        run_frame("b3C", 8'h3C, 8'hFF, 1'b1, 1'b1, 10, 12'h278);
        set_valid(1'b0);

        // Even parity, 2 stops: 0x07 -> parity 1, 48-cycle frame
        sel = 2'd1;
        @(negedge clk);
        run_frame("even07", 8'h07, 8'h00, 1'b0, 1'b0, 12, 12'hE0E);

        // Odd parity, 2 stops: 0x07 -> parity 0
        sel = 2'd2;
        @(negedge clk);
        run_frame("odd07", 8'h07, 8'h00, 1'b0, 1'b0, 12, 12'hC0E);

        // Reset during data bit 4 of 0x81
        sel = 2'd0;
        @(negedge clk);
        tdata = 8'h81;
        set_valid(1'b1);
        budget = 0;
        while (!ready_sel && budget < 100) begin
            @(negedge clk);
            budget = budget + 1;
        end
        @(posedge clk);
        #1 set_valid(1'b0);
        repeat (22) @(negedge clk);
        check("b81_bit4_pre_rst", 32'(t0), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_tx",    32'(t0), 32'd1);
        check("midrst_busy",  32'(b0), 32'd0);
        check("midrst_ready", 32'(r0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(r0), 32'd1);
        check("post_rst_tx",    32'(t0), 32'd1);
        run_frame("b42", 8'h42, 8'h00, 1'b0, 1'b0, 10, 12'h284);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
